// File: rtl/ram_reader_pkg.sv
// Shared types and constants for the RAM stream reader and its skid buffer.
package ram_reader_pkg;

    localparam int DEF_D_WIDTH = 16;
    localparam int DEF_A_WIDTH = 10;
    localparam int SKID_DEPTH  = 2;
    localparam int CNT_WIDTH   = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO; the head entry is a register so it can drive a stream directly.
module skid_fifo2
    import ram_reader_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [D_WIDTH-1:0]   din,
    input  logic                 pop,
    output logic [CNT_WIDTH-1:0] count,
    output logic [D_WIDTH-1:0]   head,
    output logic                 valid
);

    logic [D_WIDTH-1:0]   head_reg, head_next;
    logic [D_WIDTH-1:0]   tail_reg, tail_next;
    logic [CNT_WIDTH-1:0] count_reg, count_next;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        case ({push, pop})
            2'b10: begin
                if (count_reg == '0) head_next = din;
                else                 tail_next = din;
                count_next = count_reg + 1'b1;
            end
            2'b01: begin
                head_next  = tail_reg;
                count_next = count_reg - 1'b1;
            end
            2'b11: begin
                // Simultaneous push/pop: the new word lands behind whatever remains.
                if (count_reg == CNT_WIDTH'(SKID_DEPTH)) begin
                    head_next = tail_reg;
                    tail_next = din;
                end else begin
                    head_next = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign head  = head_reg;
    assign count = count_reg;
    assign valid = (count_reg != '0);

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count_reg == CNT_WIDTH'(SKID_DEPTH)));

endmodule

// File: rtl/ram_stream_reader.sv
// Sequential RAM read controller producing a valid/ready stream.
// Optional RAM_READER_STRIDE_EN adds a per-run address stride input.
module ram_stream_reader
    import ram_reader_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int A_WIDTH = DEF_A_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] base_addr,
    input  logic [A_WIDTH:0]   len,
`ifdef RAM_READER_STRIDE_EN
    input  logic [A_WIDTH-1:0] stride,
`endif
    output logic               busy,
    output logic               done,
    output logic [A_WIDTH-1:0] ram_r_addr,
    input  logic [D_WIDTH-1:0] ram_rdata,
    output logic               m_valid,
    output logic [D_WIDTH-1:0] m_data,
    input  logic               m_ready
);

    state_t               state_reg, state_next;
    logic [A_WIDTH-1:0]   addr_reg, addr_next;
    logic [A_WIDTH:0]     rem_reg, rem_next;
    logic                 pend_reg, pend_next;
    logic [A_WIDTH-1:0]   step;
    logic [CNT_WIDTH-1:0] fifo_count;
    logic [1:0]           fill;
    logic                 pop;
    logic                 issue;

`ifdef RAM_READER_STRIDE_EN
    logic [A_WIDTH-1:0] step_reg, step_next;
    assign step = step_reg;
`else
    assign step = A_WIDTH'(1);
`endif

    assign pop   = m_valid & m_ready;
    assign fill  = 2'(fifo_count) + {1'b0, pend_reg};
    // A pop in this cycle frees the slot the new read will need two cycles from now.
    assign issue = (state_reg == RUN) && (rem_reg != '0) && ((fill < 2'd2) || pop);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        rem_next   = rem_reg;
        pend_next  = 1'b0;
`ifdef RAM_READER_STRIDE_EN
        step_next  = step_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    rem_next = len;
                    if (len == '0) begin
                        state_next = FIN;
                    end else begin
                        state_next = RUN;
                        addr_next  = base_addr;
`ifdef RAM_READER_STRIDE_EN
                        step_next  = stride;
`endif
                    end
                end
            end
            RUN: begin
                if (rem_reg == '0) state_next = DRAIN;
            end
            DRAIN: begin
                // Leave as soon as the last word is being accepted so done follows it directly.
                if (!pend_reg && ((fifo_count == '0) ||
                                  (fifo_count == CNT_WIDTH'(1) && pop)))
                    state_next = FIN;
            end
            FIN: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (issue) begin
            pend_next = 1'b1;
            addr_next = addr_reg + step;
            rem_next  = rem_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            rem_reg   <= '0;
            pend_reg  <= 1'b0;
`ifdef RAM_READER_STRIDE_EN
            step_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            rem_reg   <= rem_next;
            pend_reg  <= pend_next;
`ifdef RAM_READER_STRIDE_EN
            step_reg  <= step_next;
`endif
        end
    end

    skid_fifo2 #(.D_WIDTH(D_WIDTH)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (pend_reg),
        .din   (ram_rdata),
        .pop   (pop),
        .count (fifo_count),
        .head  (m_data),
        .valid (m_valid)
    );

    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == FIN);
    assign ram_r_addr = addr_reg;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader with a behavioural one-cycle-latency RAM.
module tb_ram_stream_reader;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          m_ready = 1'b1;
`ifdef RAM_READER_STRIDE_EN
    logic [AW-1:0] stride = 10'd1;
`endif
    logic          busy, done, m_valid;
    logic [AW-1:0] ram_r_addr;
    logic [DW-1:0] ram_rdata, m_data;

    ram_stream_reader #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
`ifdef RAM_READER_STRIDE_EN
        .stride     (stride),
`endif
        .busy       (busy),
        .done       (done),
        .ram_r_addr (ram_r_addr),
        .ram_rdata  (ram_rdata),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] r_addr_q = '0;
    always @(posedge clk) r_addr_q <= ram_r_addr;
    assign ram_rdata = mem[r_addr_q];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] exp_q[$];
    int  beats = 0;
    int  done_count = 0;
    int  done_cyc = 0;
    int  first_valid_cyc = 0;
    int  start_cyc = 0;
    int  done_before = 0;
    bit  seen_valid = 0;
    bit  stalled = 0;
    logic [DW-1:0] stall_data = '0;
    bit  ready_mode = 0;
    int  ready_phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stalled)
                    check("stall_hold", {15'd0, m_valid, m_data}, {15'd0, 1'b1, stall_data});
                if (m_valid && !seen_valid) begin
                    seen_valid = 1;
                    first_valid_cyc = cyc;
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_beat: got 0x%0h, expected no beat", m_data);
                    end else begin
                        check("beat", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
                    end
                    beats++;
                end
                stalled    = m_valid && !m_ready;
                stall_data = m_data;
                if (done) begin
                    done_count++;
                    done_cyc = cyc;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    // Consumer ready: always 1, or the repeating 1,0,0,1 pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                m_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
                ready_phase++;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    task automatic start_run(input logic [AW-1:0] b, input int n);
        @(posedge clk);
        #1;
        base_addr   = b;
        len         = (AW+1)'(n);
        start       = 1'b1;
        seen_valid  = 0;
        start_cyc   = cyc;
        done_before = done_count;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        for (int i = 0; i < bound && done_count == done_before; i++) begin
            @(negedge clk);
            #1;
        end
        check({name, "_done_once"}, done_count - done_before, 1);
        repeat (3) @(negedge clk);
        #1;
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, {30'd0, busy, m_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 'h100);

        #12;
        check("reset_outputs", {3'd0, busy, done, m_valid, m_data, ram_r_addr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic run, full throughput.
        exp_q.push_back(16'h0104); exp_q.push_back(16'h0105); exp_q.push_back(16'h0106);
        exp_q.push_back(16'h0107); exp_q.push_back(16'h0108);
        start_run(10'd4, 5);
        wait_done("t1", 40);
        check("t1_first_latency", first_valid_cyc - start_cyc, 3);
        check("t1_done_time", done_cyc - start_cyc, 8);

        // Address wrap.
        exp_q.push_back(16'h04FE); exp_q.push_back(16'h04FF);
        exp_q.push_back(16'h0100); exp_q.push_back(16'h0101);
        start_run(10'd1022, 4);
        wait_done("t2_wrap", 40);
        check("t2_done_time", done_cyc - start_cyc, 7);

        // Backpressure with the 1,0,0,1 ready pattern.
        ready_phase = 0;
        ready_mode  = 1;
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h0110 + 16'(i));
        start_run(10'd16, 8);
        wait_done("t3_bp", 200);
        ready_mode = 0;
        check("t3_end_addr", {22'd0, ram_r_addr}, 32'd24);

        // Zero-length run.
        start_run(10'd500, 0);
        check("t4_fin_state", {29'd0, busy, done, m_valid}, 32'b110);
        @(posedge clk);
        #1;
        check("t4_after_fin", {29'd0, busy, done, m_valid}, 32'd0);
        check("t4_addr_kept", {22'd0, ram_r_addr}, 32'd24);
        repeat (3) @(negedge clk);
        #1;
        check("t4_done_once", done_count - done_before, 1);

        // Reset mid-run after 3 accepted words.
        for (int i = 0; i < 10; i++) exp_q.push_back(16'h0100 + 16'(i));
        begin
            int b0;
            int db;
            b0 = beats;
            start_run(10'd0, 10);
            for (int i = 0; i < 50 && beats - b0 < 3; i++) begin
                @(negedge clk);
                #1;
            end
            check("t5_three_beats", beats - b0, 3);
            @(posedge clk);
            #3;
            rst = 1'b1;
            #1;
            check("t5_async_reset", {3'd0, busy, done, m_valid, m_data, ram_r_addr}, 32'd0);
            exp_q.delete();
            db = done_count;
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            check("t5_no_done", done_count - db, 0);
        end
        exp_q.push_back(16'h0100); exp_q.push_back(16'h0101);
        start_run(10'd0, 2);
        wait_done("t5_restart", 40);
        check("t5_done_time", done_cyc - start_cyc, 5);

        // Full-depth run.
        for (int i = 0; i < (1 << AW); i++) exp_q.push_back(16'h0100 + 16'(i));
        start_run(10'd0, 1 << AW);
        wait_done("t6_full", 1200);
        check("t6_done_time", done_cyc - start_cyc, (1 << AW) + 3);

`ifdef RAM_READER_STRIDE_EN
        stride = 10'd256;
        exp_q.push_back(16'h0100); exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0300); exp_q.push_back(16'h0400);
        start_run(10'd0, 4);
        wait_done("s1_stride256", 40);
        stride = 10'd0;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h0107);
        start_run(10'd7, 4);
        wait_done("s2_stride0", 40);
        stride = 10'd1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side controller for the team's simple dual-port RAM: one-cycle read latency, read address registered inside the RAM, read data combinational from that registered address.
- On a start command, issues a run of sequential read addresses and returns the words as a valid/ready stream with full backpressure.
- Feeds weight and feature-map words from on-chip buffers into the DNN datapath, one word per cycle when the consumer is ready.

Parameters:
- D_WIDTH, 16, data word width; must match the RAM.
- A_WIDTH, 10, RAM address width; RAM depth is 2**A_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only when busy=0.
- base_addr  input  A_WIDTH  first read address; latched on accepted start.
- len  input  A_WIDTH+1  word count, 0..2**A_WIDTH; latched on accepted start.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse when the run completes.
- ram_r_addr  output  A_WIDTH  read address to the RAM r_addr.
- ram_rdata  input  D_WIDTH  RAM data_out.
- m_valid  output  1  stream data valid.
- m_data  output  D_WIDTH  stream data.
- m_ready  input  1  consumer ready.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, m_valid=0.
  - m_data=0, ram_r_addr=0.
  - Skid FIFO empty; pending-read flag cleared.
  - Reset mid-run discards in-flight and buffered words, with no done pulse.
- States:
  - IDLE: start=1 latches base_addr and len, then goes to RUN, or to FIN if len=0.
  - RUN: issues reads until remaining=0, then goes to DRAIN.
  - DRAIN: waits until the pending flag is clear and the FIFO is empty, then goes to FIN.
  - FIN: done=1 for one cycle, busy drops, then returns to IDLE.
  - start while busy=1 is ignored.
- Read issue:
  - ram_r_addr is registered and holds the current address.
  - A read is issued in a cycle when state=RUN, remaining>0, and ((fifo_cnt + pend) < 2 OR (m_valid AND m_ready)).
  - On issue: pend<=1, address increments, remaining decrements.
  - Address arithmetic is modulo 2**A_WIDTH, so base=1023, len=3 reads 1023, 0, 1.
- Return path:
  - The cycle after an issue, ram_rdata is pushed into a 2-entry skid FIFO and pend clears, unless another issue occurs.
  - The FIFO head drives m_data/m_valid directly from registers.
  - A pop happens when m_valid AND m_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - The FIFO never overflows; overflow is an assertion failure.
- Stream rules:
  - Once m_valid=1, m_data is stable until accepted.
  - Words are delivered in address order, exactly len words.
- Latency and throughput:
  - First word is valid 3 cycles after the start cycle: latch, issue, capture.
  - With m_ready held at 1, throughput is 1 word/cycle.
  - done asserts the cycle after the last word is accepted, so with m_ready=1 it is len+3 cycles after start.
- Boundaries:
  - len=2**A_WIDTH reads every location once.
  - len=0 gives busy for 1 cycle then done, with no RAM reads and m_valid never asserted.
  - m_ready=0 for arbitrary periods stalls issue after 2 words are buffered; no words are lost or duplicated.

Optional Feature:
- Macro: RAM_READER_STRIDE_EN.
- Defined:
  - Adds input stride [A_WIDTH-1:0], latched on start.
  - Each issued read advances the address by stride, modulo 2**A_WIDTH.
  - stride=0 repeats base_addr len times.
- Undefined:
  - No stride port; the increment is fixed at 1.
  - All other behaviour is identical.

Decomposition:
- Package ram_reader_pkg:
  - State enum: IDLE, RUN, DRAIN, FIN.
  - Constant SKID_DEPTH=2.
  - Default width constants.
- Sub-module skid_fifo2 (parameter D_WIDTH):
  - 2-entry register FIFO with push/pop/count/head.
  - Reusable by other stream producers in the datapath.

Test Plan:
- RAM preloaded addr[i]=i+16'h100; start base=4, len=5, m_ready=1 -> m_data 0x104..0x108 on consecutive cycles, first valid 3 cycles after start, done one cycle after the last beat.
- base=1022, len=4 -> words from addresses 1022, 1023, 0, 1 in order; no extra beats.
- len=8 with m_ready toggling 1,0,0,1 pattern -> all 8 words in order, m_data stable while stalled, never more than 2 words in flight plus buffered.
- len=0 -> busy high one cycle, done pulse, m_valid stays 0, ram_r_addr unchanged.
- rst asserted mid-run after 3 of 10 words -> all outputs return to 0 asynchronously; a new start base=0, len=2 then delivers 2 correct words.
- RAM_READER_STRIDE_EN defined: base=0, len=4, stride=256 -> words from 0, 256, 512, 768; stride=0 -> word at base repeated 4 times.
